// File: rtl/data_mem_io.sv
// Data-side RAM plus memory-mapped GPIO and prescaled timer.
// Loads are combinational; stores and register updates commit on clk.
module data_mem_io #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  memWrite,
    output logic [DATA_WIDTH-1:0] readData,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    localparam int RAM_DEPTH = (1 << DATA_WIDTH) - 16;
    localparam logic [DATA_WIDTH-1:0] ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
    logic                  en_q, en_d;
    logic                  ar_q, ar_d;
    logic [3:0]            psc_q, psc_d;
    logic [3:0]            pc_q, pc_d;
    logic [DATA_WIDTH-1:0] tcount_q, tcount_d;
    logic [DATA_WIDTH-1:0] tcmp_q, tcmp_d;
    logic                  mf_q, mf_d;

    logic                  io_sel;
    logic [3:0]            offset;
    logic                  we;
    logic                  ram_we;
    logic                  sel_gout, sel_gin, sel_tctrl;
    logic                  sel_tcount, sel_tcmp, sel_tstat;
    logic                  tick;
    logic                  match;
    logic [DATA_WIDTH-1:0] tctrl_rd;
    logic [DATA_WIDTH-1:0] rd_data;

    assign io_sel = &ALUResult[DATA_WIDTH-1 -: 4];
    assign offset = ALUResult[3:0];
    assign we     = memWrite && reset;
    assign ram_we = we && !io_sel;

    assign sel_gout   = io_sel && (offset == 4'h0);
    assign sel_gin    = io_sel && (offset == 4'h1);
    assign sel_tctrl  = io_sel && (offset == 4'h2);
    assign sel_tcount = io_sel && (offset == 4'h3);
    assign sel_tcmp   = io_sel && (offset == 4'h4);
    assign sel_tstat  = io_sel && (offset == 4'h5);

    assign tick  = en_q && (pc_q == psc_q);
    assign match = (tcount_q == tcmp_q);

    always_comb begin
        tctrl_rd      = '0;
        tctrl_rd[7:4] = psc_q;
        tctrl_rd[1]   = ar_q;
        tctrl_rd[0]   = en_q;
    end

    always_comb begin
        rd_data = '0;
        if (!io_sel) begin
            rd_data = mem_q[ALUResult];
        end else begin
            unique case (1'b1)
                sel_gout:   rd_data = gpio_out_q;
                sel_gin:    rd_data = sync_q[SYNC_STAGES-1];
                sel_tctrl:  rd_data = tctrl_rd;
                sel_tcount: rd_data = tcount_q;
                sel_tcmp:   rd_data = tcmp_q;
                sel_tstat:  rd_data = {{(DATA_WIDTH-1){1'b0}}, mf_q};
                default:    rd_data = '0;
            endcase
        end
    end

    assign readData = rd_data;

    always_comb begin
        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        en_d       = en_q;
        ar_d       = ar_q;
        psc_d      = psc_q;
        tcmp_d     = tcmp_q;
        tcount_d   = tcount_q;
        pc_d       = pc_q;
        mf_d       = mf_q;

        if (we && sel_gout) gpio_out_d = writeData;
        if (we && sel_tcmp) tcmp_d = writeData;
        if (we && sel_tctrl) begin
            en_d  = writeData[0];
            ar_d  = writeData[1];
            psc_d = writeData[7:4];
        end

        if (!en_q) begin
            pc_d = '0;
        end else if (tick) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + 4'd1;
        end

        if (we && sel_tstat && writeData[0]) mf_d = 1'b0;

        // A TCOUNT store overrides the tick and suppresses match evaluation.
        if (we && sel_tcount) begin
            tcount_d = writeData;
            pc_d     = '0;
        end else if (tick) begin
            if (match) begin
                mf_d     = 1'b1;
                tcount_d = ar_q ? '0 : tcount_q + ONE;
            end else begin
                tcount_d = tcount_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ALUResult] <= writeData;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out_q <= '0;
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            psc_q      <= '0;
            pc_q       <= '0;
            tcount_q   <= '0;
            tcmp_q     <= '1;
            mf_q       <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            gpio_out_q <= gpio_out_d;
            en_q       <= en_d;
            ar_q       <= ar_d;
            psc_q      <= psc_d;
            pc_q       <= pc_d;
            tcount_q   <= tcount_d;
            tcmp_q     <= tcmp_d;
            mf_q       <= mf_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign gpio_out  = gpio_out_q;
    assign timer_irq = mf_q;

endmodule

// File: tb/tb_data_mem_io.sv
// Scoreboard bench for data_mem_io: RAM, GPIO, timer, collisions, reset.
// Expected load values are queued when a load is driven, popped on sample.
module tb_data_mem_io;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ALUResult;
    logic [7:0] writeData;
    logic       memWrite;
    logic [7:0] readData;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       timer_irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];
    logic [7:0] model [256];

    data_mem_io #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResult (ALUResult),
        .writeData (writeData),
        .memWrite  (memWrite),
        .readData  (readData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ALUResult = a;
        writeData = d;
        memWrite  = 1'b1;
        step();
        memWrite  = 1'b0;
    endtask

    task automatic sb_pop();
        logic [7:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, readData, e);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e,
                      input string tag);
        ALUResult = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        sb_pop();
    endtask

    initial begin
        logic [7:0] addrs [8];
        logic [7:0] exp_cnt;
        reset     = 1'b0;
        ALUResult = 8'h00;
        writeData = 8'h00;
        memWrite  = 1'b0;
        gpio_in   = 8'h00;
        step();
        step();
        reset = 1'b1;

        check("rst_gpio_out", gpio_out, 8'h00);
        check("rst_irq", {7'd0, timer_irq}, 8'h00);
        rd(8'hF0, 8'h00, "rst_gout_rd");
        rd(8'hF1, 8'h00, "rst_gin");
        rd(8'hF2, 8'h00, "rst_tctrl");
        rd(8'hF3, 8'h00, "rst_tcount");
        rd(8'hF4, 8'hFF, "rst_tcmp");
        rd(8'hF5, 8'h00, "rst_tstat");

        wr(8'h10, 8'hA5);
        wr(8'hEF, 8'h3C);
        rd(8'h10, 8'hA5, "ram_10");
        rd(8'hEF, 8'h3C, "ram_ef");
        ALUResult = 8'h10;
        writeData = 8'h77;
        memWrite  = 1'b1;
        exp_q.push_back(8'hA5);
        tag_q.push_back("ram_same_cycle_old");
        #2;
        sb_pop();
        step();
        memWrite = 1'b0;
        rd(8'h10, 8'h77, "ram_10_new");

        for (int i = 0; i < 8; i++) begin
            addrs[i] = 8'h20 + 8'(i * 24) + 8'($urandom_range(0, 15));
            model[addrs[i]] = 8'($urandom);
            wr(addrs[i], model[addrs[i]]);
        end
        for (int i = 0; i < 8; i++) rd(addrs[i], model[addrs[i]], "ram_rand");

        wr(8'hF0, 8'h5A);
        check("gpio_out", gpio_out, 8'h5A);
        rd(8'hF0, 8'h5A, "gout_rd");
        wr(8'hF1, 8'hFF);
        rd(8'hF1, 8'h00, "gin_wr_ignored");
        wr(8'hF8, 8'h44);
        rd(8'hF8, 8'h00, "unused_f8");
        rd(8'hFF, 8'h00, "unused_ff");
        gpio_in = 8'hC3;
        rd(8'hF1, 8'h00, "gin_0_edges");
        step();
        rd(8'hF1, 8'h00, "gin_1_edge");
        step();
        rd(8'hF1, 8'hC3, "gin_2_edges");

        wr(8'hF2, 8'h0C);
        rd(8'hF2, 8'h00, "tctrl_mask");
        wr(8'hF2, 8'hFC);
        rd(8'hF2, 8'hF0, "tctrl_psc");
        wr(8'hF2, 8'h00);

        wr(8'hF3, 8'h00);
        wr(8'hF4, 8'h05);
        wr(8'hF2, 8'h03);
        for (int e = 1; e <= 5; e++) begin
            step();
            check("p0_irq_low", {7'd0, timer_irq}, 8'h00);
            rd(8'hF3, 8'(e), "p0_count");
        end
        step();
        check("p0_irq_edge6", {7'd0, timer_irq}, 8'h01);
        rd(8'hF5, 8'h01, "p0_mf");
        rd(8'hF3, 8'h00, "p0_reload");
        wr(8'hF5, 8'h00);
        check("w0_no_clear", {7'd0, timer_irq}, 8'h01);
        wr(8'hF5, 8'h01);
        check("w1c_clear", {7'd0, timer_irq}, 8'h00);
        rd(8'hF3, 8'h02, "count_after_w1c");
        step();
        step();
        step();
        rd(8'hF3, 8'h05, "count_pre_match");
        wr(8'hF5, 8'h01);
        check("w1c_vs_set", {7'd0, timer_irq}, 8'h01);
        rd(8'hF3, 8'h00, "match_reload2");
        wr(8'hF2, 8'h00);
        rd(8'hF3, 8'h01, "tctrl_wr_tick_old");
        step();
        rd(8'hF3, 8'h01, "disabled_hold");
        wr(8'hF5, 8'h01);
        check("clear_again", {7'd0, timer_irq}, 8'h00);

        wr(8'hF4, 8'h20);
        wr(8'hF2, 8'h01);
        wr(8'hF3, 8'h20);
        rd(8'hF3, 8'h20, "tcount_wr_wins");
        check("wr_no_match", {7'd0, timer_irq}, 8'h00);
        step();
        rd(8'hF3, 8'h21, "match_no_ar");
        check("match_no_ar_irq", {7'd0, timer_irq}, 8'h01);
        wr(8'hF2, 8'h00);
        wr(8'hF5, 8'h01);

        wr(8'hF4, 8'h10);
        wr(8'hF3, 8'hFE);
        wr(8'hF2, 8'h31);
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_cnt = (e < 4) ? 8'hFE : (e < 8) ? 8'hFF : 8'h00;
            rd(8'hF3, exp_cnt, "psc_wrap");
        end
        check("wrap_no_mf", {7'd0, timer_irq}, 8'h00);
        wr(8'hF2, 8'h00);

        wr(8'hF4, 8'h02);
        wr(8'hF3, 8'h00);
        wr(8'hF2, 8'h01);
        step();
        step();
        step();
        check("pre_rst_irq", {7'd0, timer_irq}, 8'h01);
        ALUResult = 8'h10;
        writeData = 8'h99;
        memWrite  = 1'b1;
        reset     = 1'b0;
        step();
        reset     = 1'b1;
        memWrite  = 1'b0;
        check("mid_rst_irq", {7'd0, timer_irq}, 8'h00);
        check("mid_rst_gout", gpio_out, 8'h00);
        rd(8'hF1, 8'h00, "mid_rst_gin");
        rd(8'hF2, 8'h00, "mid_rst_tctrl");
        rd(8'hF3, 8'h00, "mid_rst_tcount");
        rd(8'hF4, 8'hFF, "mid_rst_tcmp");
        rd(8'hF5, 8'h00, "mid_rst_tstat");
        rd(8'h10, 8'h77, "ram_kept_10");
        rd(8'hEF, 8'h3C, "ram_kept_ef");
        step();
        step();
        rd(8'hF3, 8'h00, "post_rst_idle");

        check("sb_empty", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
